// File: rtl/id_stage.sv
// Pipelined RV32 decode stage: register file, immediate/control decode and a valid/ready output
// register with load-use stall and flush. Define ID_STAGE_WB_BYPASS_EN to forward same-cycle WB.
module id_stage #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data,
  output logic [WIDTH-1:0] immediate,
  output logic [4:0]       rd_addr,
  output logic             branch,
  output logic             memRead,
  output logic             memToReg,
  output logic             memWrite,
  output logic             ALUSrc,
  output logic             regWrite,
  output logic [1:0]       ALUOp
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic [WIDTH-1:0] regs_q [NUM_REGS];

  logic [4:0]       rs1_idx, rs2_idx;
  logic             wb_we;
  logic [WIDTH-1:0] rs1_val, rs2_val, imm_val;
  // {ALUSrc, memToReg, regWrite, memRead, memWrite, branch, ALUOp[1:0]}
  logic [7:0]       ctrl_val;
  logic             hazard, accept;

  logic             valid_q;
  logic [WIDTH-1:0] rs1_q, rs2_q, imm_q;
  logic [4:0]       rd_q;
  logic [7:0]       ctrl_q;

  function automatic logic idx_live(logic [4:0] idx);
    return (idx != 5'd0) && ({27'd0, idx} < NUM_REGS);
  endfunction

  assign rs1_idx = instruction[19:15];
  assign rs2_idx = instruction[24:20];
  assign wb_we   = wb_en && idx_live(wb_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (idx_live(rs1_idx)) rs1_val = regs_q[rs1_idx[AW-1:0]];
    if (idx_live(rs2_idx)) rs2_val = regs_q[rs2_idx[AW-1:0]];
`ifdef ID_STAGE_WB_BYPASS_EN
    if (wb_we && (wb_addr == rs1_idx)) rs1_val = wb_data;
    if (wb_we && (wb_addr == rs2_idx)) rs2_val = wb_data;
`endif
  end

  always_comb begin
    ctrl_val = 8'b0;
    imm_val  = '0;
    case (instruction[6:0])
      OpR: ctrl_val = 8'b0010_0010;
      OpImm: begin
        ctrl_val = 8'b1010_0010;
        imm_val  = {{(WIDTH-12){instruction[31]}}, instruction[31:20]};
      end
      OpLoad: begin
        ctrl_val = 8'b1111_0000;
        imm_val  = {{(WIDTH-12){instruction[31]}}, instruction[31:20]};
      end
      OpStore: begin
        ctrl_val = 8'b1000_1000;
        imm_val  = {{(WIDTH-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OpBranch: begin
        ctrl_val = 8'b0000_0101;
        imm_val  = {{(WIDTH-13){instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  assign hazard = valid_q && ctrl_q[4] && (rd_q != 5'd0) &&
                  ((rd_q == rs1_idx) || (rd_q == rs2_idx));
  assign in_ready = ~rst & ~flush & ~hazard & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // A load-use bubble (hazard & out_ready) drains exactly like a plain consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      rs1_q   <= rs1_val;
      rs2_q   <= rs2_val;
      imm_q   <= imm_val;
      rd_q    <= instruction[11:7];
      ctrl_q  <= ctrl_val;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;
  assign immediate = imm_q;
  assign rd_addr   = rd_q;
  assign ALUSrc    = ctrl_q[7];
  assign memToReg  = ctrl_q[6];
  assign regWrite  = ctrl_q[5];
  assign memRead   = ctrl_q[4];
  assign memWrite  = ctrl_q[3];
  assign branch    = ctrl_q[2];
  assign ALUOp     = ctrl_q[1:0];

endmodule

// File: doc/id_stage.md
# id_stage

Pipelined instruction-decode stage for the RISC-V core: decodes a 32-bit instruction, reads a parametrised register file, generates the immediate and control bits, and holds everything in an output pipeline register with a valid/ready handshake. It sits between fetch and execute. It adds a load-use hazard stall, a flush input and an optional write-back bypass, none of which the previous combinational decode had.

## Interface
- `WIDTH`, 32: datapath width for register data and the immediate, at least 32.
- `NUM_REGS`, 32: number of architectural registers, a power of 2 in 2..32. Register 0 always reads zero.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `in_valid` in 1: fetch presents `instruction`.
- `in_ready` out 1: the stage accepts the instruction this cycle.
- `instruction` in 32: RV32 instruction word.
- `flush` in 1: discards the output register contents and the presented instruction.
- `wb_en` in 1: register-file write enable.
- `wb_addr` in 5: write register index.
- `wb_data` in WIDTH: write data.
- `out_valid` out 1: the output register holds a real instruction.
- `out_ready` in 1: execute consumes the output this cycle.
- `rs1_data`, `rs2_data` out WIDTH: registered operand values.
- `immediate` out WIDTH: registered sign-extended immediate.
- `rd_addr` out 5: registered destination index, `instruction[11:7]`.
- `branch`, `memRead`, `memToReg`, `memWrite`, `ALUSrc`, `regWrite` out 1 each: registered control bits.
- `ALUOp` out 2: registered ALU operation class.

## Operation
- **Decode.** Decode is driven by opcode `instruction[6:0]`. Control bits are listed as ALUSrc, memToReg, regWrite, memRead, memWrite, branch, followed by ALUOp.
  - 0110011 (R): 0,0,1,0,0,0, 10
  - 0010011 (I-ALU): 1,0,1,0,0,0, 10
  - 0000011 (load): 1,1,1,1,0,0, 00
  - 0100011 (store): 1,0,0,0,1,0, 00
  - 1100011 (branch): 0,0,0,0,0,1, 01
  - Any other opcode: all zero, treated as a NOP and still passed through as valid.
- **Immediate.** Sign-extended from `instruction[31]` to WIDTH.
  - I-format (loads, I-ALU): `[31:20]`.
  - S-format: `{[31:25],[11:7]}`.
  - B-format: `{[31],[7],[30:25],[11:8],1'b0}`.
  - Any other opcode: 0.
- **Register file.** NUM_REGS x WIDTH flops, read combinationally at `instruction[19:15]` and `[24:20]`.
  - An index of 0, or an index ≥ NUM_REGS, reads 0.
  - A write happens at the clock edge when `wb_en` is set, `wb_addr` is nonzero and `wb_addr` < NUM_REGS. Otherwise the write is ignored.
  - Writes proceed regardless of stall, flush or handshake state.
- **Hazard.** `hazard` = `out_valid & memRead(out) & rd_addr≠0 & (rd_addr==rs1 | rd_addr==rs2)`.
  - Both source fields are compared for every opcode.
- **Ready.** `in_ready = ~rst & ~flush & ~hazard & (~out_valid | out_ready)`.
- **Output register update**, evaluated in priority order at each edge:
  1. `flush`: `out_valid` goes to 0 and the data is don't-care.
  2. `in_valid & in_ready`: capture the decode results and set `out_valid` to 1.
  3. `hazard & out_ready`: insert a bubble by clearing `out_valid` to 0. The instruction stays presented and is accepted on the following cycle.
  4. `out_ready`: `out_valid` goes to 0.
  5. Otherwise: hold all outputs.
- **Simultaneous events.**
  - `flush` together with `in_valid`: the instruction is dropped.
  - `flush` together with `wb_en`: the write completes.

## Timing
- **Reset.** While `rst` is asserted, every output register, every register-file entry and `out_valid` are 0, and `in_ready` is 0. Release of reset takes effect at the next clock edge with no extra idle cycle.
- **Latency.** An instruction accepted at edge N appears on the outputs after edge N, one cycle.
- **Throughput.** One instruction per cycle when `out_ready` is high and there is no hazard.
- **Load-use.** A load followed by a dependent instruction costs exactly one bubble cycle.
- **Back-pressure.** While `out_valid & ~out_ready`, all outputs are stable and `in_ready` is 0.
- **Reset mid-operation.** An asynchronous `rst` clears `out_valid` and the register file immediately. A pending instruction is lost.

## Configuration
- **`ID_STAGE_WB_BYPASS_EN` defined:** when a write and a read to the same nonzero register fall in the same cycle, the read returns `wb_data`. This lets a write-back and a decode of the consumer coincide.
- **Not defined:** reads return the pre-write value. The new value is visible from the next cycle, and the upstream pipeline must space such instructions.

## Test plan
- **Reset:** assert `rst` mid-stream -> `out_valid`=0 and `in_ready`=0 immediately. After release, a read of x5 returns 0.
- **Arithmetic:** write x3=0x10 through WB, then present I-ALU `addi x4,x3,-1` (0xFFF18213) -> next cycle `rs1_data`=0x10, `immediate`=0xFFFFFFFF, ALUSrc=1, regWrite=1, ALUOp=10, `rd_addr`=4.
- **Load-use:** `lw x6,0(x1)` then `add x7,x6,x2` with `out_ready`=1 -> one cycle with `out_valid`=0 and `in_ready`=0, then the add is accepted.
- **Back-pressure / flush:** hold `out_ready`=0 for 3 cycles -> outputs are unchanged and `in_ready`=0. Then `flush`=1 with `in_valid`=1 -> `out_valid`=0 and the instruction is not accepted.
- **Bypass:** write x9=0xABCD in the same cycle x9 is decoded -> `rs1_data` is 0xABCD with `ID_STAGE_WB_BYPASS_EN` defined, and the old value without it.
- **Parameters:** with `NUM_REGS`=16, a WB to x20 is ignored and a read of x20 returns 0. Write to x0 -> a later read of x0 returns 0.
